// File: rtl/contador_mod6_pkg.sv
// Shared timer definitions: digit width, tens modulus and the BCD digit type
// used by the units, tens and minutes counters.
package contador_mod6_pkg;

    localparam int TENS_MOD = 6;
    localparam int DIGIT_W  = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage : contador_mod6_pkg

// File: rtl/contador_mod6.sv
// Tens-of-seconds digit of the microwave countdown: loadable mod-6 BCD down
// counter with async active-high clear, terminal-count borrow and zero flag.
module contador_mod6
    import contador_mod6_pkg::*;
#(
    parameter int MODULUS = TENS_MOD,
    parameter int WIDTH   = DIGIT_W
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] data,
    input  logic             loadn,
    input  logic             en,
    output logic [WIDTH-1:0] tens,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Keypad digits beyond the top of the range saturate instead of wrapping.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] d);
        return (d > MAX_VAL) ? MAX_VAL : d;
    endfunction

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            tens <= '0;
        end else if (!loadn) begin
            tens <= clamp(data);
        end else if (tens > MAX_VAL) begin
            // Recover from an illegal register value on any count or hold edge.
            tens <= MAX_VAL;
        end else if (en) begin
            tens <= (tens == '0) ? MAX_VAL : tens - 1'b1;
        end
    end

    assign zero = (tens == '0);
    // While clearing there is no load, so the borrow follows en alone.
    assign tc   = en & zero & (loadn | clrn);

endmodule : contador_mod6

// File: tb/tb_contador_mod6.sv
// Directed and randomized checks of contador_mod6 against an arithmetic
// reference model of the tens digit.
module tb_contador_mod6;

    logic       clk = 1'b0;
    logic       clrn;
    logic [3:0] data;
    logic       loadn;
    logic       en;
    logic [3:0] tens;
    logic       tc;
    logic       zero;

    int n_checks = 0;
    int n_errors = 0;
    int model;
    int tc_count;

    contador_mod6 dut (
        .clk   (clk),
        .clrn  (clrn),
        .data  (data),
        .loadn (loadn),
        .en    (en),
        .tens  (tens),
        .tc    (tc),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int exp_zero;
        int exp_tc;
        exp_zero = (model == 0) ? 1 : 0;
        exp_tc   = (en && model == 0 && (loadn || clrn)) ? 1 : 0;
        chk({tag, ".tens"}, int'(tens), model);
        chk({tag, ".zero"}, int'(zero), exp_zero);
        chk({tag, ".tc"},   int'(tc),   exp_tc);
    endtask

    // Model one rising edge with the inputs currently applied, then sample
    // 1 time unit after the edge.
    task automatic tick();
        if (clrn)        model = 0;
        else if (!loadn) model = (data > 5) ? 5 : int'(data);
        else if (en)     model = (model + 5) % 6;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d);
        data = 4'(d); loadn = 1'b0; en = 1'b0;
        tick();
        loadn = 1'b1;
    endtask

    initial begin
        // Reset asserted asynchronously with load and count requests active.
        clrn = 1'b0; data = 4'd7; loadn = 1'b0; en = 1'b1;
        #2;
        clrn = 1'b1;
        #1;
        model = 0;
        chk_all("reset_async");
        chk("reset_tc_high", int'(tc), 1);
        @(posedge clk); #1;
        chk_all("reset_held_over_edge");
        #2;
        clrn = 1'b0; loadn = 1'b1; en = 1'b0;
        #1;
        chk_all("reset_release_before_edge");
        tick();
        chk_all("reset_release_after_edge");

        // Legal load then hold.
        load(3);
        chk_all("load3");
        tick();
        chk_all("hold3");

        // Clamped loads.
        load(6);
        chk_all("load6_clamp");
        load(15);
        chk_all("load15_clamp");

        // Count and wrap from 2: 1,0,5,4.
        load(2);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("count_wrap_%0d", i));
        end

        // Load beats count while at zero.
        load(0);
        en = 1'b1; loadn = 1'b0; data = 4'd4;
        #1;
        chk_all("prio_before_edge");
        chk("prio_tc_low", int'(tc), 0);
        tick();
        loadn = 1'b1;
        chk_all("prio_load4");
        tick();
        chk_all("prio_count");
        #2;
        clrn = 1'b1;
        #1;
        model = 0;
        chk_all("clear_mid_count");
        #1;
        clrn = 1'b0;
        #1;
        chk_all("clear_released");

        // Twelve edges from 5: two full sequences, tc once per sequence.
        load(5);
        en = 1'b1;
        tc_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (tc) tc_count++;
            tick();
            chk_all($sformatf("full_cycle_%0d", i));
        end
        chk("full_cycle_tc_pulses", tc_count, 2);
        chk("full_cycle_end_value", int'(tens), 5);

        // Randomized traffic with occasional asynchronous clears.
        for (int i = 0; i < 300; i++) begin
            data  = 4'($urandom_range(0, 15));
            loadn = ($urandom_range(0, 5) != 0);
            en    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                #2;
                clrn = 1'b1;
                #1;
                model = 0;
                chk_all($sformatf("rand_clear_%0d", i));
                clrn = 1'b0;
                #1;
            end else begin
                #1;
                chk_all($sformatf("rand_pre_%0d", i));
            end
            tick();
            chk_all($sformatf("rand_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_contador_mod6
